foreground_line_prefetcher: RTL and testbench

- Parametrised next-generation foreground sprite engine.
- Before each scanline is shown, it scans object memory and selects the objects that cover the requested line. It renders up to MAX_PER_LINE of them into one of NUM_LINE_BUFFERS line buffers.
- During display it serves pixels from the buffer tagged with the current display_y_i.
- It adds per-line sprite limit, overflow/drop reporting, tagged buffers and priority resolution.
- Sits between OBM/PMF read ports and the GPU pixel mixer.

---
 rtl/foreground_line_prefetcher.sv | 220 ++++++++++++++++++++++
 tb/tb_foreground_line_prefetcher.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/foreground_line_prefetcher.sv
// Foreground sprite line prefetcher: builds tagged scanline buffers from
// object/pattern memory and serves registered pixels to the GPU mixer.
module foreground_line_prefetcher #(
  parameter int unsigned NUM_OBJECTS      = 64,
  parameter int unsigned NUM_LINE_BUFFERS = 2,
  parameter int unsigned MAX_PER_LINE     = 16
) (
  input  logic                           gpu_clk,
  input  logic                           rst,
  input  logic                           prefetch_start_i,
  input  logic [7:0]                     prefetch_y_i,
  output logic                           busy_o,
  output logic                           overflow_o,
  output logic                           dropped_o,
  output logic [$clog2(NUM_OBJECTS)-1:0] obm_addr_o,
  input  logic [31:0]                    obm_object_i,
  output logic [7:0]                     pmf_addr_o,
  input  logic [15:0]                    pmf_line_i,
  input  logic [7:0]                     display_x_i,
  input  logic [7:0]                     display_y_i,
  output logic [1:0]                     r_o,
  output logic [1:0]                     g_o,
  output logic [1:0]                     b_o,
  output logic                           valid_o
);
  localparam int unsigned IW = $clog2(NUM_OBJECTS);
  localparam int unsigned BW = $clog2(NUM_LINE_BUFFERS);
  localparam int unsigned CW = $clog2(MAX_PER_LINE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SCAN_ADDR, S_SCAN_EVAL, S_FETCH, S_CAPTURE, S_DRAW
  } state_t;

  state_t state_q, state_d;

  logic [7:0]                  line_y_q;
  logic [BW-1:0]               wr_ptr_q;
  logic [IW-1:0]               idx_q;
  logic [CW-1:0]               cnt_q;
  logic [7:0]                  clr_x_q;
  logic [2:0]                  draw_i_q;
  logic [7:0]                  obj_x_q;
  logic [4:0]                  pmfa_q;
  logic                        hflip_q, vflip_q;
  logic [2:0]                  rgb_q;
  logic [2:0]                  row_q;
  logic [15:0]                 pat_q;
  logic [NUM_LINE_BUFFERS-1:0] tag_valid_q;
  logic [7:0]                  tag_y_q [NUM_LINE_BUFFERS];
  logic [4:0]                  lbuf [NUM_LINE_BUFFERS][256];
  logic                        busy_q, overflow_q, dropped_q;

  // Incoming object decode and vertical hit test (9-bit difference, no wrap)
  logic [7:0] ob_x, ob_y, ob_conf;
  logic [2:0] ob_rgb;
  logic [8:0] ob_diff;
  logic       ob_hit, take_hit, last_obj, publish;
  logic [5:0] unused_obj_bits;

  assign ob_x     = obm_object_i[31:24];
  assign ob_y     = obm_object_i[23:16];
  assign ob_conf  = obm_object_i[15:8];
  assign ob_rgb   = obm_object_i[2:0];
  assign unused_obj_bits = {obm_object_i[15], obm_object_i[7:3]};
  assign ob_diff  = {1'b0, line_y_q} - {1'b0, ob_y};
  assign ob_hit   = (ob_diff < 9'd8);
  assign take_hit = ob_hit && (cnt_q < CW'(MAX_PER_LINE));
  assign last_obj = (idx_q == IW'(NUM_OBJECTS - 1));

  // Draw-stage pixel selection and write qualification
  logic [2:0] col;
  logic [1:0] px_l;
  logic [8:0] px_x;
  logic [4:0] px_old;
  logic       draw_we;

  assign col     = hflip_q ? ~draw_i_q : draw_i_q;
  assign px_l    = pat_q[{~col, 1'b0} +: 2];
  assign px_x    = {1'b0, obj_x_q} + {6'd0, draw_i_q};
  assign px_old  = lbuf[wr_ptr_q][px_x[7:0]];
  assign draw_we = (state_q == S_DRAW) && (px_l != 2'd0) && !px_x[8] && (px_old[4:3] == 2'd0);

  assign obm_addr_o = idx_q;
  assign pmf_addr_o = {pmfa_q, vflip_q ? ~row_q : row_q};
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;
  assign dropped_o  = dropped_q;

  // Next-state logic; publish fires when the last object has been handled
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    case (state_q)
      S_IDLE:      if (prefetch_start_i) state_d = S_CLEAR;
      S_CLEAR:     if (clr_x_q == 8'hFF) state_d = S_SCAN_ADDR;
      S_SCAN_ADDR: state_d = S_SCAN_EVAL;
      S_SCAN_EVAL: begin
        if (take_hit) state_d = S_FETCH;
        else if (last_obj) begin
          state_d = S_IDLE;
          publish = 1'b1;
        end else state_d = S_SCAN_ADDR;
      end
      S_FETCH:     state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_DRAW;
      S_DRAW: begin
        if (draw_i_q == 3'd7) begin
          if (last_obj) begin
            state_d = S_IDLE;
            publish = 1'b1;
          end else state_d = S_SCAN_ADDR;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Control state: FSM, status flags, buffer rotation and tag validity
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      tag_valid_q <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dropped_q <= prefetch_start_i && busy_q;
      if (state_q == S_IDLE && prefetch_start_i) begin
        tag_valid_q[wr_ptr_q] <= 1'b0;
        overflow_q            <= 1'b0;
        busy_q                <= 1'b1;
      end
      if (state_q == S_SCAN_EVAL && ob_hit && !take_hit) overflow_q <= 1'b1;
      if (publish) begin
        tag_valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q              <= wr_ptr_q + BW'(1);
        busy_q                <= 1'b0;
      end
    end
  end

  // Build datapath: counters, latched object fields, captured pattern, tags
  always_ff @(posedge gpu_clk) begin
    case (state_q)
      S_IDLE: begin
        if (prefetch_start_i) line_y_q <= prefetch_y_i;
        clr_x_q <= '0;
      end
      S_CLEAR: begin
        clr_x_q <= clr_x_q + 8'd1;
        idx_q   <= '0;
        cnt_q   <= '0;
      end
      S_SCAN_EVAL: begin
        if (take_hit) begin
          cnt_q    <= cnt_q + CW'(1);
          obj_x_q  <= ob_x;
          pmfa_q   <= ob_conf[4:0];
          hflip_q  <= ob_conf[5];
          vflip_q  <= ob_conf[6];
          rgb_q    <= ob_rgb;
          row_q    <= ob_diff[2:0];
          draw_i_q <= '0;
        end else idx_q <= idx_q + IW'(1);
      end
      S_CAPTURE: pat_q <= pmf_line_i;
      S_DRAW: begin
        draw_i_q <= draw_i_q + 3'd1;
        if (draw_i_q == 3'd7) idx_q <= idx_q + IW'(1);
      end
      default: ;
    endcase
    if (publish) tag_y_q[wr_ptr_q] <= line_y_q;
  end

  // Line buffer storage: clear sweep, then first-writer-wins pixel draws
  always_ff @(posedge gpu_clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) lbuf[wr_ptr_q][clr_x_q] <= '0;
      else if (draw_we) lbuf[wr_ptr_q][px_x[7:0]] <= {px_l, rgb_q};
    end
  end

  // Display lookup: lowest-index valid buffer tagged with the display line
  logic          disp_hit;
  logic [BW-1:0] disp_buf;
  logic [4:0]    disp_e;
  logic [1:0]    disp_l;

  always_comb begin
    disp_hit = 1'b0;
    disp_buf = '0;
    for (int unsigned b = NUM_LINE_BUFFERS; b > 0; b--) begin
      if (tag_valid_q[b-1] && tag_y_q[b-1] == display_y_i) begin
        disp_hit = 1'b1;
        disp_buf = BW'(b - 1);
      end
    end
  end

  assign disp_e = lbuf[disp_buf][display_x_i];
  assign disp_l = disp_hit ? disp_e[4:3] : 2'd0;

  // Registered pixel output
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      r_o     <= '0;
      g_o     <= '0;
      b_o     <= '0;
      valid_o <= 1'b0;
    end else begin
      r_o     <= disp_l & {2{disp_e[2]}};
      g_o     <= disp_l & {2{disp_e[1]}};
      b_o     <= disp_l & {2{disp_e[0]}};
      valid_o <= (disp_l != 2'd0);
    end
  end
endmodule

// File: tb/tb_foreground_line_prefetcher.sv
// Self-checking bench for foreground_line_prefetcher with OBM/PMF models
// and a pixel scoreboard.
module tb_foreground_line_prefetcher;
  localparam int unsigned BUDGET = 600;

  logic        gpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        prefetch_start_i = 1'b0;
  logic [7:0]  prefetch_y_i = '0;
  logic        busy_o, overflow_o, dropped_o;
  logic [5:0]  obm_addr_o;
  logic [31:0] obm_object_i;
  logic [7:0]  pmf_addr_o;
  logic [15:0] pmf_line_i;
  logic [7:0]  display_x_i = '0, display_y_i = '0;
  logic [1:0]  r_o, g_o, b_o;
  logic        valid_o;

  logic [31:0] obm_mem [64];
  logic [15:0] pmf_mem [256];

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] sb [$];
  logic       probe_v = 1'b0;
  logic       probe_d = 1'b0;

  foreground_line_prefetcher #(
    .NUM_OBJECTS(64),
    .NUM_LINE_BUFFERS(2),
    .MAX_PER_LINE(16)
  ) dut (
    .gpu_clk(gpu_clk),
    .rst(rst),
    .prefetch_start_i(prefetch_start_i),
    .prefetch_y_i(prefetch_y_i),
    .busy_o(busy_o),
    .overflow_o(overflow_o),
    .dropped_o(dropped_o),
    .obm_addr_o(obm_addr_o),
    .obm_object_i(obm_object_i),
    .pmf_addr_o(pmf_addr_o),
    .pmf_line_i(pmf_line_i),
    .display_x_i(display_x_i),
    .display_y_i(display_y_i),
    .r_o(r_o),
    .g_o(g_o),
    .b_o(b_o),
    .valid_o(valid_o)
  );

  always #5 gpu_clk = ~gpu_clk;

  // Synchronous-read memory models: data valid the cycle after the address
  always @(posedge gpu_clk) begin
    obm_object_i <= obm_mem[obm_addr_o];
    pmf_line_i   <= pmf_mem[pmf_addr_o];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obj(input logic [7:0] x, input logic [7:0] y,
                                      input logic [7:0] conf, input logic [2:0] rgb);
    return {x, y, conf, 5'd0, rgb};
  endfunction

  function automatic logic [6:0] pix(input logic [1:0] l, input logic [2:0] rgb);
    return {l & {2{rgb[2]}}, l & {2{rgb[1]}}, l & {2{rgb[0]}}, l != 2'd0};
  endfunction

  // Scoreboard consumer: output registered one cycle after the probe
  always @(posedge gpu_clk) probe_d <= probe_v;

  always @(negedge gpu_clk) begin
    if (probe_d) begin
      if (sb.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
      else check_eq("pixel", {25'd0, r_o, g_o, b_o, valid_o}, {25'd0, sb.pop_front()});
    end
  end

  task automatic probe(input logic [7:0] y, input logic [7:0] x, input logic [6:0] exp);
    @(negedge gpu_clk);
    display_y_i = y;
    display_x_i = x;
    probe_v     = 1'b1;
    sb.push_back(exp);
  endtask

  task automatic drain();
    @(negedge gpu_clk);
    probe_v = 1'b0;
    @(negedge gpu_clk);
  endtask

  task automatic clear_objs();
    for (int i = 0; i < 64; i++) obm_mem[i] = obj(8'd0, 8'hF0, 8'd0, 3'd0);
  endtask

  task automatic start_build(input logic [7:0] y);
    @(negedge gpu_clk);
    prefetch_y_i     = y;
    prefetch_start_i = 1'b1;
    @(negedge gpu_clk);
    prefetch_start_i = 1'b0;
    check_eq("busy_rise", busy_o, 1);
    check_eq("no_drop_on_accept", dropped_o, 0);
  endtask

  task automatic finish_build(input logic exp_ovf);
    int cyc = 0;
    while (busy_o && cyc < BUDGET) begin
      @(negedge gpu_clk);
      cyc++;
    end
    check_eq("build_done", busy_o, 0);
    check_eq("overflow", overflow_o, exp_ovf);
  endtask

  task automatic build(input logic [7:0] y, input logic exp_ovf);
    start_build(y);
    finish_build(exp_ovf);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_objs();
    for (int i = 0; i < 256; i++) pmf_mem[i] = 16'h0000;
    pmf_mem[{5'd1, 3'd2}] = 16'hC000;
    pmf_mem[{5'd1, 3'd4}] = 16'hC000;
    pmf_mem[{5'd1, 3'd5}] = 16'h4000;
    for (int r = 0; r < 8; r++) pmf_mem[{5'd2, 3'(r)}] = 16'hFFFF;

    repeat (3) @(negedge gpu_clk);
    rst = 1'b0;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_drop", dropped_o, 0);
    check_eq("rst_pix", {r_o, g_o, b_o, valid_o}, 0);
    probe(8'd10, 8'd20, 7'd0);
    drain();

    // Basic red pixel, no flip
    obm_mem[0] = obj(8'd20, 8'd8, 8'h01, 3'b100);
    build(8'd10, 1'b0);
    probe(8'd10, 8'd20, pix(2'd3, 3'b100));
    probe(8'd10, 8'd21, 7'd0);
    probe(8'd11, 8'd20, 7'd0);
    drain();

    // Horizontal flip on line 12 (row 4)
    obm_mem[0] = obj(8'd20, 8'd8, 8'h21, 3'b100);
    build(8'd12, 1'b0);
    probe(8'd12, 8'd27, pix(2'd3, 3'b100));
    probe(8'd12, 8'd20, 7'd0);
    drain();

    // Vertical flip: line 10 row 2 fetches row 5 (lightness 1)
    obm_mem[0] = obj(8'd20, 8'd8, 8'h41, 3'b100);
    build(8'd10, 1'b0);
    probe(8'd10, 8'd20, pix(2'd1, 3'b100));
    probe(8'd12, 8'd27, pix(2'd3, 3'b100));
    drain();

    // Priority: lower object index wins overlapping pixels
    clear_objs();
    obm_mem[3] = obj(8'd100, 8'd50, 8'h02, 3'b001);
    obm_mem[7] = obj(8'd100, 8'd50, 8'h02, 3'b010);
    build(8'd50, 1'b0);
    probe(8'd50, 8'd100, pix(2'd3, 3'b001));
    probe(8'd50, 8'd107, pix(2'd3, 3'b001));
    probe(8'd50, 8'd108, 7'd0);
    drain();

    // Overflow: 20 hits, only the first 16 drawn
    clear_objs();
    for (int k = 10; k < 30; k++) obm_mem[k] = obj(8'(8 * (k - 10)), 8'd40, 8'h02, 3'b111);
    build(8'd40, 1'b1);
    probe(8'd40, 8'd0, pix(2'd3, 3'b111));
    probe(8'd40, 8'd127, pix(2'd3, 3'b111));
    probe(8'd40, 8'd128, 7'd0);
    probe(8'd40, 8'd159, 7'd0);
    drain();
    clear_objs();
    build(8'd41, 1'b0);

    // Horizontal clipping at the right edge
    obm_mem[0] = obj(8'd252, 8'd100, 8'h02, 3'b100);
    build(8'd100, 1'b0);
    probe(8'd100, 8'd252, pix(2'd3, 3'b100));
    probe(8'd100, 8'd255, pix(2'd3, 3'b100));
    probe(8'd100, 8'd0, 7'd0);
    probe(8'd100, 8'd3, 7'd0);
    drain();

    // No vertical wrap: y=0xFC does not cover line 0, does cover 253
    obm_mem[0] = obj(8'd252, 8'hFC, 8'h02, 3'b100);
    build(8'd0, 1'b0);
    probe(8'd0, 8'd252, 7'd0);
    drain();
    build(8'd253, 1'b0);
    probe(8'd253, 8'd253, pix(2'd3, 3'b100));
    drain();

    // Start while busy is dropped and does not disturb the build
    obm_mem[0] = obj(8'd30, 8'd58, 8'h02, 3'b010);
    start_build(8'd60);
    repeat (5) @(negedge gpu_clk);
    prefetch_y_i     = 8'd61;
    prefetch_start_i = 1'b1;
    @(negedge gpu_clk);
    prefetch_start_i = 1'b0;
    check_eq("drop_pulse", dropped_o, 1);
    @(negedge gpu_clk);
    check_eq("drop_end", dropped_o, 0);
    finish_build(1'b0);
    probe(8'd60, 8'd30, pix(2'd3, 3'b010));
    probe(8'd61, 8'd30, 7'd0);
    drain();

    // Reset mid-scan abandons the build and invalidates all lines
    start_build(8'd70);
    repeat (300) @(negedge gpu_clk);
    probe(8'd60, 8'd30, pix(2'd3, 3'b010));
    drain();
    check_eq("mid_build_busy", busy_o, 1);
    rst = 1'b1;
    @(negedge gpu_clk);
    check_eq("rst_mid_busy", busy_o, 0);
    check_eq("rst_mid_valid", valid_o, 0);
    rst = 1'b0;
    probe(8'd60, 8'd30, 7'd0);
    drain();
    build(8'd60, 1'b0);
    probe(8'd60, 8'd30, pix(2'd3, 3'b010));
    drain();

    check_eq("sb_leftover", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
